div_unit: RTL and testbench

//  Multi-cycle integer divider that serves the EX stage's DIV/DIVU requests over a start/ready handshake.
//  EX holds start_i with operands and stalls the pipeline until ready_o.
//  It then forwards result_o to the HI/LO write path: HI = remainder, LO = quotient.

---
 rtl/div_unit_pkg.sv | 19 +
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 111 +++++++++++
 tb/tb_div_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared divider state codes, handshake levels and aluop codes
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on {rem, quo}
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   partial;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    // The shifted remainder needs WIDTH+1 bits: it can reach 2*divisor-1.
    always_comb begin
        partial  = acc[2*WIDTH-1:WIDTH-1];
        diff     = {1'b0, partial} - {2'b00, divisor};
        borrow   = diff[WIDTH+1];
        acc_next = {borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0],
                    acc[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring DIV/DIVU unit with start/ready handshake
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   divisor;
    logic               neg_quo;
    logic               neg_rem;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        mag1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        quo_fix = neg_quo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .divisor  (divisor),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            acc      <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        cnt <= '0;
                        if (opdata2_i == '0) begin
                            state <= DIV_BYZERO;
                        end else begin
                            state   <= DIV_ON;
                            acc     <= {{WIDTH{1'b0}}, mag1};
                            divisor <= mag2;
                            neg_quo <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_rem <= signed_div_i && opdata1_i[WIDTH-1];
                        end
                    end
                end
                // Two cycles here so a zero divisor reports ready two edges after acceptance.
                DIV_BYZERO: begin
                    if (cnt == CNT_W'(1)) begin
                        state    <= DIV_END;
                        cnt      <= '0;
                        result_o <= '0;
                        ready_o  <= DivResultReady;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state    <= DIV_FREE;
                        cnt      <= '0;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end else if (cnt == CNT_W'(WIDTH)) begin
                        state    <= DIV_END;
                        cnt      <= '0;
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= DivResultReady;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV_END: begin
                    if (start_i == DivStop) begin
                        state    <= DIV_FREE;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed scoreboard bench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int n;
        logic [63:0] exp;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        exp_q.push_back(exp_res);
        @(posedge clk);
        #1;
        check({tag, "_ready_after_accept"}, 64'(ready_o), 64'd0);
        @(negedge clk);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~sgn;
        n = 1;
        @(posedge clk);
        #1;
        while (!ready_o && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, "_result"}, result_o, exp);
        end else begin
            check({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
            exp = 64'd0;
        end
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_release"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    initial begin
        int seen;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E);
        run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);
        run_op("div_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 33, 64'hFFFFFFFF_00000003);
        run_op("div_5_0", 1'b1, 32'd5, 32'd0, 2, 64'd0);
        run_op("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 33, 64'h00000000_FFFFFFFF);
        run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);
        run_op("divu_min_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 33, 64'h80000000_00000000);

        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("annul_outputs", {63'd0, ready_o} | result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen++;
        end
        check("annul_never_ready", 64'(seen), 64'd0);
        run_op("after_annul_9_3", 1'b0, 32'd9, 32'd3, 33, 64'h00000000_00000003);

        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midop_reset_outputs", {63'd0, ready_o} | result_o, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o || result_o != 64'd0) seen++;
        end
        check("post_reset_idle", 64'(seen), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
